alu_md: RTL and testbench

Parametrised multi-cycle ALU for the single-cycle core's next revision. It adds the RV32M multiply/divide operations to the base integer ALU operations. It sits between decode and writeback and uses valid/ready handshakes on both sides, so the core can stall on long operations. Base operations complete in one cycle. Multiply and divide use a shared iterative datapath that takes XLEN cycles.

---
 rtl/alu_md_pkg.sv | 67 ++++++
 rtl/alu_md_iter.sv | 80 ++++++++
 rtl/alu_md.sv | 181 ++++++++++++++++++
 tb/tb_alu_md.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_md_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md_pkg
//  Description : Shared types and op-decode helpers for the multi-cycle ALU
//                (base integer ops plus RV32M multiply/divide).
//  Revision    : 1.0  initial release
// ============================================================================
package alu_md_pkg;

    localparam int OP_W = 5;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD    = 5'd0,
        ALU_SUB    = 5'd1,
        ALU_SLL    = 5'd2,
        ALU_SLT    = 5'd3,
        ALU_SLTU   = 5'd4,
        ALU_XOR    = 5'd5,
        ALU_SRL    = 5'd6,
        ALU_SRA    = 5'd7,
        ALU_OR     = 5'd8,
        ALU_AND    = 5'd9,
        ALU_MUL    = 5'd10,
        ALU_MULH   = 5'd11,
        ALU_MULHSU = 5'd12,
        ALU_MULHU  = 5'd13,
        ALU_DIV    = 5'd14,
        ALU_DIVU   = 5'd15,
        ALU_REM    = 5'd16,
        ALU_REMU   = 5'd17
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        MODE_MUL = 1'b0,
        MODE_DIV = 1'b1
    } iter_mode_e;

    function automatic logic is_mul(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_MULHSU) || (op == ALU_MULHU);
    endfunction

    function automatic logic is_div(input logic [OP_W-1:0] op);
        return (op == ALU_DIV) || (op == ALU_DIVU) ||
               (op == ALU_REM) || (op == ALU_REMU);
    endfunction

    // Operand A is treated as signed for MUL, MULH, MULHSU, DIV and REM.
    function automatic logic is_signed_a(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) || (op == ALU_MULHSU) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

    // Operand B is treated as signed for MUL, MULH, DIV and REM.
    function automatic logic is_signed_b(input logic [OP_W-1:0] op);
        return (op == ALU_MUL) || (op == ALU_MULH) ||
               (op == ALU_DIV) || (op == ALU_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_md_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md_iter
//  Description : Shared iterative datapath: unsigned shift-add multiply and
//                restoring divide on operand magnitudes, one bit per cycle.
//                Multiply: acc = {hi, multiplier}, final acc = product.
//                Divide  : acc = {rem, dividend}, final acc = {rem, quotient}.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_md_iter
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  iter_mode_e        mode,
    input  logic [XLEN-1:0]   op_a,
    input  logic [XLEN-1:0]   op_b,
    output logic [2*XLEN-1:0] acc_nxt,
    output logic              done
);

    localparam int            CW   = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opnd;
    logic [CW-1:0]     r_cnt;
    logic              r_run;
    iter_mode_e        r_mode;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_diff;

    // One iteration step: add-then-shift-right for multiply, shift-left-then-trial-subtract for divide
    always_comb begin
        w_sum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
        w_rem_sh = r_acc[2*XLEN-1:XLEN-1];
        w_diff   = w_rem_sh - {1'b0, r_opnd};
        if (r_mode == MODE_MUL) begin
            acc_nxt = {w_sum, r_acc[XLEN-1:1]};
        end else if (!w_diff[XLEN]) begin
            acc_nxt = {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        end else begin
            // Restore: the shifted partial remainder was below the divisor, so its top bit is zero
            acc_nxt = {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
        end
    end

    // The step that finishes is the one taken while the counter still reads XLEN-1
    assign done = r_run && (r_cnt == LAST);

    // Operand load on start, then XLEN steps; the counter ends at XLEN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_mode <= MODE_MUL;
        end else if (start) begin
            r_acc  <= {{XLEN{1'b0}}, op_a};
            r_opnd <= op_b;
            r_cnt  <= '0;
            r_run  <= 1'b1;
            r_mode <= mode;
        end else if (r_run) begin
            r_acc <= acc_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) begin
                r_run <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : alu_md
//  Description : Multi-cycle ALU with valid/ready handshakes. Base ops and
//                divide short-cuts complete in one cycle; MUL*/DIV* run on
//                the shared iterative datapath for XLEN cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_md
    import alu_md_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_by_zero
);

    localparam int SHW = $clog2(XLEN);

    state_e            r_state;
    state_e            w_state_nxt;
    logic [4:0]        r_op;
    logic              r_neg_q;
    logic              r_neg_r;
    logic [XLEN-1:0]   r_result;
    logic              r_dbz;

    logic              w_accept;
    logic              w_iter_start;
    logic              w_iter_done;
    logic [2*XLEN-1:0] w_acc_nxt;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quick;
    logic [XLEN-1:0]   w_post;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [SHW-1:0]    w_shamt;
    logic              w_sa;
    logic              w_sb;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_long;

    // Sign pre-processing and short-cut detection on the live request
    assign w_sa       = is_signed_a(op) && a[XLEN-1];
    assign w_sb       = is_signed_b(op) && b[XLEN-1];
    assign w_a_mag    = w_sa ? -a : a;
    assign w_b_mag    = w_sb ? -b : b;
    assign w_shamt    = b[SHW-1:0];
    assign w_div_zero = is_div(op) && (b == '0);
    assign w_div_ovf  = ((op == ALU_DIV) || (op == ALU_REM)) &&
                        (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    assign w_long     = is_mul(op) || (is_div(op) && !w_div_zero && !w_div_ovf);
    assign w_accept   = in_valid && in_ready;

    // Single-cycle results: base ops, illegal ops and divide short-cuts
    always_comb begin
        w_quick = '0;
        case (op)
            ALU_ADD:  w_quick = a + b;
            ALU_SUB:  w_quick = a - b;
            ALU_SLL:  w_quick = a << w_shamt;
            ALU_SLT:  w_quick = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: w_quick = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  w_quick = a ^ b;
            ALU_SRL:  w_quick = a >> w_shamt;
            ALU_SRA:  w_quick = $signed(a) >>> w_shamt;
            ALU_OR:   w_quick = a | b;
            ALU_AND:  w_quick = a & b;
            // Only reached as a short-cut: b=0 gives all-ones, overflow gives a
            ALU_DIV, ALU_DIVU: w_quick = w_div_zero ? '1 : a;
            // b=0 gives a, overflow gives 0
            ALU_REM, ALU_REMU: w_quick = w_div_zero ? a : '0;
            default:  w_quick = '0;
        endcase
    end

    // Sign post-processing of the final iteration value
    always_comb begin
        w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
        w_post = '0;
        case (r_op)
            ALU_MUL:                          w_post = w_prod[XLEN-1:0];
            ALU_MULH, ALU_MULHSU, ALU_MULHU:  w_post = w_prod[2*XLEN-1:XLEN];
            ALU_DIV, ALU_DIVU:  w_post = r_neg_q ? -w_acc_nxt[XLEN-1:0] : w_acc_nxt[XLEN-1:0];
            ALU_REM, ALU_REMU:  w_post = r_neg_r ? -w_acc_nxt[2*XLEN-1:XLEN] : w_acc_nxt[2*XLEN-1:XLEN];
            default:                          w_post = '0;
        endcase
    end

    alu_md_iter #(
        .XLEN    (XLEN)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (w_iter_start),
        .mode    (is_div(op) ? MODE_DIV : MODE_MUL),
        .op_a    (w_a_mag),
        .op_b    (w_b_mag),
        .acc_nxt (w_acc_nxt),
        .done    (w_iter_done)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs; in_ready is forced low while in reset
    always_comb begin
        w_state_nxt  = r_state;
        w_iter_start = 1'b0;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = rst_n;
                if (in_valid && rst_n) begin
                    if (w_long) begin
                        w_state_nxt  = BUSY;
                        w_iter_start = 1'b1;
                    end else begin
                        w_state_nxt  = DONE;
                    end
                end
            end
            BUSY: begin
                if (w_iter_done) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Request latch and result register; result only moves on entry to DONE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
            r_dbz    <= 1'b0;
        end else if (w_accept) begin
            r_op    <= op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            if (!w_long) begin
                r_result <= w_quick;
                r_dbz    <= w_div_zero;
            end
        end else if ((r_state == BUSY) && w_iter_done) begin
            r_result <= w_post;
            r_dbz    <= 1'b0;
        end
    end

    assign result      = r_result;
    assign div_by_zero = r_dbz;

endmodule
`default_nettype wire

// File: tb/tb_alu_md.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_md
//  Description : Directed self-checking bench for alu_md at XLEN=32.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_md;
    import alu_md_pkg::*;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        dbz;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    alu_md #(
        .XLEN        (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .op          (op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Issue one request, measure latency from the accept edge, then complete the handshake
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] res, output logic dbz, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
        end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        dbz = div_by_zero;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state in_ready=%b out_valid=%b result=%h dbz=%b required 0 0 00000000 0",
                     in_ready, out_valid, result, div_by_zero);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_base();
        vec_t v[$];
        logic [31:0] res;
        logic        dbz;
        int          lat;
        v.push_back('{ALU_ADD,  32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0});
        v.push_back('{ALU_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0});
        v.push_back('{ALU_SUB,  32'd5,        32'd7,        32'hFFFFFFFE, 1'b0});
        v.push_back('{ALU_SLL,  32'd1,        32'h0000003F, 32'h80000000, 1'b0});
        v.push_back('{ALU_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0});
        v.push_back('{ALU_SLTU, 32'hFFFFFFFF, 32'd1,        32'h00000000, 1'b0});
        v.push_back('{ALU_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0});
        v.push_back('{ALU_SRL,  32'h80000000, 32'h00000024, 32'h08000000, 1'b0});
        v.push_back('{ALU_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0});
        v.push_back('{ALU_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0});
        v.push_back('{5'd20,    32'd5,        32'd5,        32'h00000000, 1'b0});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, dbz, lat);
            checks++;
            if (res !== v[i].exp || dbz !== 1'b0) begin
                errors++;
                $display("FAIL base_result op=%0d result=%h dbz=%b required %h 0", v[i].op, res, dbz, v[i].exp);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL base_latency op=%0d latency=%0d required 1", v[i].op, lat);
            end
        end
    endtask

    task automatic test_mul();
        vec_t v[$];
        logic [31:0] res;
        logic        dbz;
        int          lat;
        v.push_back('{ALU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 1'b0});
        v.push_back('{ALU_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 1'b0});
        v.push_back('{ALU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0});
        v.push_back('{ALU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, dbz, lat);
            checks++;
            if (res !== v[i].exp || dbz !== 1'b0) begin
                errors++;
                $display("FAIL mul_result op=%0d result=%h dbz=%b required %h 0", v[i].op, res, dbz, v[i].exp);
            end
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL mul_latency op=%0d latency=%0d required 33", v[i].op, lat);
            end
        end
    endtask

    task automatic test_div();
        vec_t v[$];
        logic [31:0] res;
        logic        dbz;
        int          lat;
        v.push_back('{ALU_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0});
        v.push_back('{ALU_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0});
        v.push_back('{ALU_DIVU, 32'd100,      32'd7,        32'd14,       1'b0});
        v.push_back('{ALU_REMU, 32'd100,      32'd7,        32'd2,        1'b0});
        v.push_back('{ALU_DIV,  32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0});
        v.push_back('{ALU_REM,  32'd100,      32'hFFFFFFF9, 32'd2,        1'b0});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, dbz, lat);
            checks++;
            if (res !== v[i].exp || dbz !== 1'b0) begin
                errors++;
                $display("FAIL div_result op=%0d result=%h dbz=%b required %h 0", v[i].op, res, dbz, v[i].exp);
            end
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL div_latency op=%0d latency=%0d required 33", v[i].op, lat);
            end
        end
    endtask

    task automatic test_shortcut();
        vec_t v[$];
        logic [31:0] res;
        logic        dbz;
        int          lat;
        v.push_back('{ALU_DIVU, 32'd1234,     32'd0,        32'hFFFFFFFF, 1'b1});
        v.push_back('{ALU_DIV,  32'd5,        32'd0,        32'hFFFFFFFF, 1'b1});
        v.push_back('{ALU_REM,  32'd5,        32'd0,        32'd5,        1'b1});
        v.push_back('{ALU_REMU, 32'd9,        32'd0,        32'd9,        1'b1});
        v.push_back('{ALU_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0});
        v.push_back('{ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0});
        foreach (v[i]) begin
            run_op(v[i].op, v[i].a, v[i].b, res, dbz, lat);
            checks++;
            if (res !== v[i].exp || dbz !== v[i].dbz) begin
                errors++;
                $display("FAIL shortcut_result op=%0d result=%h dbz=%b required %h %b",
                         v[i].op, res, dbz, v[i].exp, v[i].dbz);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL shortcut_latency op=%0d latency=%0d required 1", v[i].op, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        op = ALU_MUL; a = 32'd6; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        // A second request is held pending for the whole operation
        op = ALU_ADD; a = 32'd1; b = 32'd1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            checks++;
            if (in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_busy_ready cycle=%0d in_ready=%b required 0", lat, in_ready);
            end
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat !== 33) begin
            errors++;
            $display("FAIL bp_latency latency=%0d required 33", lat);
        end
        repeat (10) begin
            checks++;
            if (out_valid !== 1'b1 || result !== 32'd42 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold out_valid=%b result=%h in_ready=%b required 1 0000002a 0",
                         out_valid, result, in_ready);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_idle_gap out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || result !== 32'd2) begin
            errors++;
            $display("FAIL bp_pending_op out_valid=%b result=%h required 1 00000002", out_valid, result);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_busy();
        logic [31:0] res;
        logic        dbz;
        int          lat;
        int          seen;
        op = ALU_DIV; a = 32'd100; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 32'h0 || div_by_zero !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset out_valid=%b result=%h dbz=%b in_ready=%b required 0 00000000 0 0",
                     out_valid, result, div_by_zero, in_ready);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_no_partial out_valid_cycles=%0d in_ready=%b required 0 1", seen, in_ready);
        end
        run_op(ALU_ADD, 32'd2, 32'd3, res, dbz, lat);
        checks++;
        if (res !== 32'd5 || lat !== 1) begin
            errors++;
            $display("FAIL post_reset_add result=%h latency=%0d required 00000005 1", res, lat);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_base();
        test_mul();
        test_div();
        test_shortcut();
        test_backpressure();
        test_reset_mid_busy();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
